riscv_hazard_ctrl: RTL and testbench

- Parametrised hazard, forwarding and redirect controller for the RISC-V pipeline family; successor to the fixed 3-stage single-source forwarding logic.
- Tracks the destinations of in-flight instructions in an internal scoreboard over NUM_FWD post-execute stages and selects the youngest forwarding source.
- Generates load-use stalls for configurable load latency, IF/D flushes on branch/jump/mret, and synchronised, prioritised interrupt take requests.
- Adds saturating stall and flush performance counters.

---
 rtl/riscv_hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_riscv_hazard_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_hazard_ctrl.sv
// Pipeline hazard controller: in-flight destination scoreboard with youngest-source
// forwarding, load-use stalls, IF/D flushes, synchronised interrupt takes, perf counters.
module riscv_hazard_ctrl #(
    parameter  int unsigned REGW     = 5,
    parameter  int unsigned NUM_FWD  = 2,
    parameter  int unsigned LOAD_LAT = 1,
    parameter  int unsigned CNTW     = 16,
    localparam int unsigned FSW      = $clog2(NUM_FWD + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            ex_valid_i,
    input  logic [REGW-1:0] ex_rs1_i,
    input  logic [REGW-1:0] ex_rs2_i,
    input  logic            ex_rs1_used_i,
    input  logic            ex_rs2_used_i,
    input  logic [REGW-1:0] ex_rd_i,
    input  logic            ex_reg_write_i,
    input  logic            ex_is_load_i,
    input  logic            br_taken_i,
    input  logic            is_mret_i,
    input  logic            t_intr_i,
    input  logic            e_intr_i,
    input  logic            mie_i,
    output logic [FSW-1:0]  fwd_a_o,
    output logic [FSW-1:0]  fwd_b_o,
    output logic            stall_fd_o,
    output logic            flush_o,
    output logic            intr_take_o,
    output logic            intr_cause_o,
    output logic [CNTW-1:0] stall_cnt_o,
    output logic [CNTW-1:0] flush_cnt_o
);

    logic [NUM_FWD-1:0] sb_valid;
    logic [NUM_FWD-1:0] sb_wr;
    logic [NUM_FWD-1:0] sb_ld;
    logic [REGW-1:0]    sb_rd [NUM_FWD];

    logic [2:0]      t_sync;
    logic [2:0]      e_sync;
    logic            pend_t;
    logic            pend_e;
    logic [CNTW-1:0] stall_cnt;
    logic [CNTW-1:0] flush_cnt;

    logic           stall;
    logic           take;
    logic           flush;
    logic           lu_a;
    logic           lu_b;
    logic [FSW-1:0] sel_a;
    logic [FSW-1:0] sel_b;

    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        lu_a  = 1'b0;
        lu_b  = 1'b0;
        for (int unsigned k = NUM_FWD; k > 0; k--) begin
            if (sb_valid[k-1] && sb_wr[k-1] && (sb_rd[k-1] == ex_rs1_i) &&
                (ex_rs1_i != '0) && ex_rs1_used_i) begin
                sel_a = FSW'(k);
                lu_a  = sb_ld[k-1] && (k < LOAD_LAT);
            end
            if (sb_valid[k-1] && sb_wr[k-1] && (sb_rd[k-1] == ex_rs2_i) &&
                (ex_rs2_i != '0) && ex_rs2_used_i) begin
                sel_b = FSW'(k);
                lu_b  = sb_ld[k-1] && (k < LOAD_LAT);
            end
        end
    end

    assign stall = lu_a | lu_b;
    assign take  = mie_i & (pend_e | pend_t) & ~stall & ~br_taken_i & ~is_mret_i;
    assign flush = (br_taken_i | is_mret_i | take) & ~stall;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sb_valid <= '0;
            sb_wr    <= '0;
            sb_ld    <= '0;
            for (int unsigned k = 0; k < NUM_FWD; k++) begin
                sb_rd[k] <= '0;
            end
        end else begin
            // Stalled or interrupted instructions enter as bubbles; the shift never holds.
            sb_valid[0] <= ex_valid_i & ~stall & ~take;
            sb_wr[0]    <= ex_reg_write_i;
            sb_ld[0]    <= ex_is_load_i;
            sb_rd[0]    <= ex_rd_i;
            for (int unsigned k = 1; k < NUM_FWD; k++) begin
                sb_valid[k] <= sb_valid[k-1];
                sb_wr[k]    <= sb_wr[k-1];
                sb_ld[k]    <= sb_ld[k-1];
                sb_rd[k]    <= sb_rd[k-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            t_sync <= '0;
            e_sync <= '0;
            pend_t <= 1'b0;
            pend_e <= 1'b0;
        end else begin
            t_sync <= {t_sync[1:0], t_intr_i};
            e_sync <= {e_sync[1:0], e_intr_i};
            // Only the taken source clears; a coincident new edge re-sets it.
            pend_e <= (pend_e & ~(take & pend_e)) | (e_sync[1] & ~e_sync[2]);
            pend_t <= (pend_t & ~(take & ~pend_e)) | (t_sync[1] & ~t_sync[2]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNTW'(1);
            end
            if (flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNTW'(1);
            end
        end
    end

    assign fwd_a_o      = sel_a;
    assign fwd_b_o      = sel_b;
    assign stall_fd_o   = stall;
    assign flush_o      = flush;
    assign intr_take_o  = take;
    assign intr_cause_o = pend_e;
    assign stall_cnt_o  = stall_cnt;
    assign flush_cnt_o  = flush_cnt;

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Scoreboard bench for riscv_hazard_ctrl: three configurations share one stimulus
// stream; a spec-level model queues expected outputs, a negedge monitor compares.
module tb_riscv_hazard_ctrl;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, ex_valid, u1, u2, wr, ld, br, mret, t_in, e_in, mie;
    logic [4:0] rs1, rs2, rd;
    logic       nrst, nbr, nmret, nt, ne, nmie;

    logic [1:0]  fa0, fb0, fa1, fb1;
    logic        fa2, fb2;
    logic [2:0]  stl, flu, tke, cse;
    logic [15:0] sc0, fc0;
    logic [2:0]  sc1, fc1;
    logic [3:0]  sc2, fc2;

    riscv_hazard_ctrl #(.REGW(5), .NUM_FWD(2), .LOAD_LAT(2), .CNTW(16)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .ex_valid_i(ex_valid), .ex_rs1_i(rs1), .ex_rs2_i(rs2),
        .ex_rs1_used_i(u1), .ex_rs2_used_i(u2), .ex_rd_i(rd), .ex_reg_write_i(wr),
        .ex_is_load_i(ld), .br_taken_i(br), .is_mret_i(mret), .t_intr_i(t_in), .e_intr_i(e_in),
        .mie_i(mie), .fwd_a_o(fa0), .fwd_b_o(fb0), .stall_fd_o(stl[0]), .flush_o(flu[0]),
        .intr_take_o(tke[0]), .intr_cause_o(cse[0]), .stall_cnt_o(sc0), .flush_cnt_o(fc0));

    riscv_hazard_ctrl #(.REGW(5), .NUM_FWD(3), .LOAD_LAT(3), .CNTW(3)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .ex_valid_i(ex_valid), .ex_rs1_i(rs1), .ex_rs2_i(rs2),
        .ex_rs1_used_i(u1), .ex_rs2_used_i(u2), .ex_rd_i(rd), .ex_reg_write_i(wr),
        .ex_is_load_i(ld), .br_taken_i(br), .is_mret_i(mret), .t_intr_i(t_in), .e_intr_i(e_in),
        .mie_i(mie), .fwd_a_o(fa1), .fwd_b_o(fb1), .stall_fd_o(stl[1]), .flush_o(flu[1]),
        .intr_take_o(tke[1]), .intr_cause_o(cse[1]), .stall_cnt_o(sc1), .flush_cnt_o(fc1));

    riscv_hazard_ctrl #(.REGW(5), .NUM_FWD(1), .LOAD_LAT(1), .CNTW(4)) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .ex_valid_i(ex_valid), .ex_rs1_i(rs1), .ex_rs2_i(rs2),
        .ex_rs1_used_i(u1), .ex_rs2_used_i(u2), .ex_rd_i(rd), .ex_reg_write_i(wr),
        .ex_is_load_i(ld), .br_taken_i(br), .is_mret_i(mret), .t_intr_i(t_in), .e_intr_i(e_in),
        .mie_i(mie), .fwd_a_o(fa2), .fwd_b_o(fb2), .stall_fd_o(stl[2]), .flush_o(flu[2]),
        .intr_take_o(tke[2]), .intr_cause_o(cse[2]), .stall_cnt_o(sc2), .flush_cnt_o(fc2));

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
    } rec_t;

    typedef struct {
        string               nm;
        logic [NI-1:0][1:0]  fa;
        logic [NI-1:0][1:0]  fb;
        logic [NI-1:0]       st;
        logic [NI-1:0]       fl;
        logic [NI-1:0]       tk;
        logic [NI-1:0]       cs;
        logic [NI-1:0][15:0] sc;
        logic [NI-1:0][15:0] fc;
    } exp_t;

    exp_t expq[$];
    int   nchk = 0;
    int   nerr = 0;

    // Reference state: hist[i][age] = instruction issued age+1 cycles ago.
    rec_t       hist [NI][3];
    logic       pe [NI];
    logic       pt [NI];
    int         mscnt [NI];
    int         mfcnt [NI];
    logic [3:0] eh, th;

    function automatic int nf(input int i);
        return (i == 0) ? 2 : (i == 1) ? 3 : 1;
    endfunction
    function automatic int ll(input int i);
        return (i == 0) ? 2 : (i == 1) ? 3 : 1;
    endfunction
    function automatic int cmax(input int i);
        return (i == 0) ? 65535 : (i == 1) ? 7 : 15;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            for (int a = 0; a < 3; a++) hist[i][a] = '0;
            pe[i] = 1'b0;
            pt[i] = 1'b0;
            mscnt[i] = 0;
            mfcnt[i] = 0;
        end
        eh = '0;
        th = '0;
    endtask

    function automatic int youngest(input int i, input logic [4:0] src, input logic used);
        if (!used || src == 5'd0) return -1;
        for (int a = 0; a < nf(i); a++) begin
            if (hist[i][a].v && hist[i][a].wr && hist[i][a].rd == src) return a;
        end
        return -1;
    endfunction

    task automatic eval(input string nm);
        exp_t e;
        int   ya, yb, s, f;
        logic rise_e, rise_t, clr_e, clr_t;
        if (!rst_n) model_reset();
        e.nm = nm;
        for (int i = 0; i < NI; i++) begin
            ya = youngest(i, rs1, u1);
            yb = youngest(i, rs2, u2);
            e.fa[i] = (ya < 0) ? 2'd0 : 2'(ya + 1);
            e.fb[i] = (yb < 0) ? 2'd0 : 2'(yb + 1);
            e.st[i] = (ya >= 0 && hist[i][ya].ld && ya < ll(i) - 1) ||
                      (yb >= 0 && hist[i][yb].ld && yb < ll(i) - 1);
            e.tk[i] = mie && (pe[i] || pt[i]) && !e.st[i] && !br && !mret;
            e.cs[i] = pe[i];
            e.fl[i] = (br || mret || e.tk[i]) && !e.st[i];
            e.sc[i] = 16'(mscnt[i]);
            e.fc[i] = 16'(mfcnt[i]);
        end
        expq.push_back(e);
        if (rst_n) begin
            rise_e = eh[1] && !eh[2];
            rise_t = th[1] && !th[2];
            for (int i = 0; i < NI; i++) begin
                clr_e = e.tk[i] && pe[i];
                clr_t = e.tk[i] && !pe[i];
                pe[i] = (pe[i] && !clr_e) || rise_e;
                pt[i] = (pt[i] && !clr_t) || rise_t;
                for (int a = 2; a > 0; a--) hist[i][a] = hist[i][a-1];
                hist[i][0] = {ex_valid && !e.st[i] && !e.tk[i], rd, wr, ld};
                s = mscnt[i] + (e.st[i] ? 1 : 0);
                f = mfcnt[i] + (e.fl[i] ? 1 : 0);
                mscnt[i] = (s > cmax(i)) ? cmax(i) : s;
                mfcnt[i] = (f > cmax(i)) ? cmax(i) : f;
            end
            eh = {eh[2:0], e_in};
            th = {th[2:0], t_in};
        end
    endtask

    task automatic step(input string nm, input logic v, input logic [4:0] r1, input logic uu1,
                        input logic [4:0] r2, input logic uu2, input logic [4:0] d,
                        input logic w, input logic l);
        @(posedge clk);
        #1;
        ex_valid = v; rs1 = r1; u1 = uu1; rs2 = r2; u2 = uu2; rd = d; wr = w; ld = l;
        br = nbr; mret = nmret; t_in = nt; e_in = ne; mie = nmie;
        rst_n = nrst;
        eval(nm);
    endtask

    task automatic nop(input string nm);
        step(nm, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exv);
        nchk++;
        if (act !== exv) begin
            nerr++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exv);
        end
    endfunction

    initial begin : monitor
        exp_t               e;
        logic [NI-1:0][1:0]  afa, afb;
        logic [NI-1:0][15:0] asc, afc;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e   = expq.pop_front();
                afa = {{1'b0, fa2}, fa1, fa0};
                afb = {{1'b0, fb2}, fb1, fb0};
                asc = {16'(sc2), 16'(sc1), sc0};
                afc = {16'(fc2), 16'(fc1), fc0};
                for (int i = 0; i < NI; i++) begin
                    chk($sformatf("%s fwd_a[%0d]", e.nm, i), 32'(afa[i]), 32'(e.fa[i]));
                    chk($sformatf("%s fwd_b[%0d]", e.nm, i), 32'(afb[i]), 32'(e.fb[i]));
                    chk($sformatf("%s stall[%0d]", e.nm, i), 32'(stl[i]), 32'(e.st[i]));
                    chk($sformatf("%s flush[%0d]", e.nm, i), 32'(flu[i]), 32'(e.fl[i]));
                    chk($sformatf("%s take[%0d]", e.nm, i), 32'(tke[i]), 32'(e.tk[i]));
                    if (e.tk[i]) chk($sformatf("%s cause[%0d]", e.nm, i), 32'(cse[i]), 32'(e.cs[i]));
                    chk($sformatf("%s stall_cnt[%0d]", e.nm, i), 32'(asc[i]), 32'(e.sc[i]));
                    chk($sformatf("%s flush_cnt[%0d]", e.nm, i), 32'(afc[i]), 32'(e.fc[i]));
                end
            end
        end
    end

    initial begin : stim
        bit slipped;
        rst_n = 1'b0; nrst = 1'b0;
        ex_valid = 1'b0; rs1 = '0; rs2 = '0; u1 = 1'b0; u2 = 1'b0; rd = '0; wr = 1'b0; ld = 1'b0;
        br = 1'b0; mret = 1'b0; t_in = 1'b0; e_in = 1'b0; mie = 1'b1;
        nbr = 1'b0; nmret = 1'b0; nt = 1'b0; ne = 1'b0; nmie = 1'b1;
        model_reset();

        nop("reset0");
        nop("reset1");
        nrst = 1'b1;
        nop("post_reset");

        step("addi_x5",   1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0);
        step("fwd_adj",   1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0);
        step("addi_x5",   1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0);
        step("unrelated", 1, 5'd1, 1, 5'd2, 1, 5'd9, 1, 0);
        step("fwd_gap",   1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0);
        step("addi_x5a",  1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0);
        step("addi_x5b",  1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0);
        step("youngest",  1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0);
        step("wr_x0",     1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0);
        step("rd_x0",     1, 5'd0, 1, 5'd0, 1, 5'd3, 1, 0);
        step("wr_x5",     1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0);
        step("rs2_unused",1, 5'd4, 1, 5'd5, 0, 5'd3, 1, 0);

        step("lw_x7",     1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 1);
        repeat (3) step("load_use", 1, 5'd7, 1, 5'd1, 1, 5'd8, 1, 0);

        nbr = 1'b1; nop("branch");
        nbr = 1'b0; nop("after_branch");
        step("lw_x7_br",  1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 1);
        nbr = 1'b1; step("br_in_stall", 1, 5'd7, 1, 5'd1, 1, 5'd8, 1, 0);
        step("br_reexec", 1, 5'd7, 1, 5'd1, 1, 5'd8, 1, 0);
        nbr = 1'b0;
        nmret = 1'b1; nop("mret");
        nmret = 1'b0;

        ne = 1'b1; nt = 1'b1;
        repeat (6) nop("intr_both");
        ne = 1'b0; nt = 1'b0;
        repeat (4) nop("intr_idle");

        ne = 1'b1; nt = 1'b1; slipped = 1'b0;
        for (int c = 0; c < 8; c++) begin
            nbr = (!slipped && (pe[0] || pt[0]));
            if (nbr) slipped = 1'b1;
            nop("intr_slip");
        end
        nbr = 1'b0; ne = 1'b0; nt = 1'b0;
        repeat (3) nop("intr_idle2");

        nmie = 1'b0; nt = 1'b1;
        repeat (6) nop("mie_off");
        nmie = 1'b1;
        repeat (3) nop("mie_on");
        nt = 1'b0;

        for (int r = 0; r < 5; r++) begin
            step("sat_lw",  1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 1);
            repeat (3) step("sat_use", 1, 5'd1, 1, 5'd7, 1, 5'd8, 1, 0);
        end

        ne = 1'b1;
        step("rst_lw",    1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 1);
        nrst = 1'b0;
        step("rst_async", 1, 5'd7, 1, 5'd1, 1, 5'd8, 1, 0);
        step("rst_hold",  1, 5'd7, 1, 5'd1, 1, 5'd8, 1, 0);
        nrst = 1'b1; ne = 1'b0;
        repeat (5) nop("rst_release");

        for (int r = 0; r < 500; r++) begin
            nbr   = ($urandom_range(0, 9) == 0);
            nmret = ($urandom_range(0, 29) == 0);
            nmie  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 19) == 0) ne = ~ne;
            if ($urandom_range(0, 19) == 0) nt = ~nt;
            step("random", 1'($urandom_range(0, 3) != 0),
                 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 2) == 0));
        end

        repeat (3) @(posedge clk);
        chk("queue_drain", 32'(expq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
